// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard scoreboard and its flush sequencer.
// Optional feature macro: HZ_PERF_CNT_EN (stall-cycle performance counter).
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_FLUSH = 2'd2
  } flush_state_e;

  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'hBFC00380;
  localparam logic [31:0] ERET_TYPE_DEFAULT = 32'h0000000e;

  // Counter field is sized for the widest supported latency field; LAT_W must not exceed it.
  localparam int unsigned SB_CNT_W = 8;

  typedef struct packed {
    logic                busy;
    logic                is_var;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  localparam sb_entry_t SB_ENTRY_CLEAR = '0;

  // ERET returns to the saved EPC; every other exception enters the common vector.
  function automatic logic [31:0] redirect_target(input logic [31:0] exc_type,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] eret_type,
                                                  input logic [31:0] exc_vec);
    return (exc_type == eret_type) ? epc : exc_vec;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_flush_fsm.sv
// Exception flush/redirect sequencer: holds a pending exception while data
// memory is busy, then issues a one-cycle flush with the redirect target.
// Optional feature macro of the enclosing block: HZ_PERF_CNT_EN (not used here).
module hz_flush_fsm
  import hazard_scoreboard_pkg::*;
#(
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter logic [31:0] ERET_TYPE = ERET_TYPE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_stall_i,
  input  logic [31:0] exc_type_i,
  input  logic [31:0] exc_epc_i,
  output logic        in_wait_o,
  output logic        flush_all_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  flush_state_e state_q;
  logic         flush_q;
  logic         redirect_valid_q;
  logic [31:0]  redirect_pc_q;
  logic [31:0]  target_q;
  logic [31:0]  target_now;

  assign target_now = redirect_target(exc_type_i, exc_epc_i, ERET_TYPE, EXC_VEC);

  // Sequencer state and registered flush/redirect outputs; the target is latched
  // when the exception is first seen so a WAIT period cannot alter it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= FS_IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      target_q         <= '0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
          if (exc_type_i != '0) begin
            target_q <= target_now;
            if (d_stall_i) begin
              state_q <= FS_WAIT;
            end else begin
              state_q          <= FS_FLUSH;
              flush_q          <= 1'b1;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= target_now;
            end
          end
        end
        FS_WAIT: begin
          if (!d_stall_i) begin
            state_q          <= FS_FLUSH;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= target_q;
          end
        end
        FS_FLUSH: begin
          state_q          <= FS_IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
        end
        default: begin
          state_q          <= FS_IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          redirect_pc_q    <= '0;
        end
      endcase
    end
  end

  assign in_wait_o        = (state_q == FS_WAIT);
  assign flush_all_o      = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: per-register scoreboard for fixed and
// variable latency producers, stall generation, and exception flush/redirect.
// Optional feature macro: HZ_PERF_CNT_EN adds the stall_cycles counter port.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter int unsigned RAW       = 5,
  parameter int unsigned LAT_W     = 3,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter logic [31:0] ERET_TYPE = ERET_TYPE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs,
  input  logic [RAW-1:0]   id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [RAW-1:0]   id_wr_reg,
  input  logic [LAT_W-1:0] id_wr_lat,
  input  logic             id_wr_var,
  input  logic             var_done,
  input  logic [RAW-1:0]   var_reg,
  input  logic             pipe_stall,
  input  logic             d_stall,
  input  logic [31:0]      exc_type,
  input  logic [31:0]      exc_epc,
  output logic             stall_issue,
  output logic             flush_all,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  sb_entry_t sb_q [NREG];
  sb_entry_t sb_d [NREG];

  logic raw_hz;
  logic waw_hz;
  logic in_wait;
  logic issue;

  hz_flush_fsm #(
    .EXC_VEC   (EXC_VEC),
    .ERET_TYPE (ERET_TYPE)
  ) u_flush_fsm (
    .clk_i            (clk),
    .rst_i            (rst),
    .d_stall_i        (d_stall),
    .exc_type_i       (exc_type),
    .exc_epc_i        (exc_epc),
    .in_wait_o        (in_wait),
    .flush_all_o      (flush_all),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  // Hazard detection against the registered scoreboard; register 0 is skipped.
  always_comb begin
    raw_hz = 1'b0;
    waw_hz = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (sb_q[r].busy) begin
        if (id_rs_used && (id_rs == RAW'(r))) raw_hz = 1'b1;
        if (id_rt_used && (id_rt == RAW'(r))) raw_hz = 1'b1;
        if (sb_q[r].is_var && (id_wr_reg == RAW'(r))) waw_hz = 1'b1;
      end
    end
  end

  assign stall_issue = in_wait | (id_valid & (raw_hz | waw_hz));
  assign issue       = id_valid & ~stall_issue & ~pipe_stall & ~flush_all;

  // Scoreboard next state; later assignments take priority: countdown, then
  // var completion, then a new issue, and a flush overrides everything.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      sb_d[r] = sb_q[r];
      if (r == 0) begin
        sb_d[r] = SB_ENTRY_CLEAR;
      end else begin
        if (!pipe_stall && sb_q[r].busy && !sb_q[r].is_var && (sb_q[r].cnt != '0)) begin
          sb_d[r].cnt = sb_q[r].cnt - SB_CNT_W'(1);
          if (sb_q[r].cnt == SB_CNT_W'(1)) sb_d[r].busy = 1'b0;
        end
        if (var_done && (var_reg == RAW'(r)) && sb_q[r].busy && sb_q[r].is_var) begin
          sb_d[r] = SB_ENTRY_CLEAR;
        end
        if (issue && id_wr_en && (id_wr_reg == RAW'(r))) begin
          sb_d[r].is_var = id_wr_var;
          sb_d[r].busy   = id_wr_var | (id_wr_lat != '0);
          sb_d[r].cnt    = SB_CNT_W'(id_wr_lat);
        end
        if (flush_all) sb_d[r] = SB_ENTRY_CLEAR;
      end
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) sb_q[r] <= SB_ENTRY_CLEAR;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) sb_q[r] <= sb_d[r];
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_issue && !pipe_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Saturating count of unfrozen stall cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  // No performance counter in this build.
`endif

endmodule
